// File: rtl/primus_alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between N_REQ requesters.
// A tag pipeline tracks the owner of each in-flight operation so results can be routed back.
module primus_alu_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4,
  parameter int LATENCY = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*OP_W-1:0]    req_op_i,
  input  logic [N_REQ*DATA_W-1:0]  req_a_i,
  input  logic [N_REQ*DATA_W-1:0]  req_b_i,
  output logic                     alu_valid_o,
  output logic [OP_W-1:0]          alu_op_o,
  output logic [DATA_W-1:0]        alu_a_o,
  output logic [DATA_W-1:0]        alu_b_o,
  input  logic                     alu_done_i,
  input  logic [DATA_W-1:0]        alu_result_i,
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand;
  logic            gnt_found;
  logic            hs;

  logic                          iss_vld_p0;
  logic [ID_W-1:0]               iss_id_p0;
  logic [LATENCY-1:0]            tag_vld_p1;
  logic [LATENCY-1:0]            tag_kill_p1;
  logic [LATENCY-1:0][ID_W-1:0]  tag_id_p1;

  logic            out_vld;
  logic            out_kill;
  logic [ID_W-1:0] out_id;

  // Arbitration: scan from ptr_q upward with wrap, first valid requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!gnt_found && req_valid_i[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Reset gates the grant so every output reads zero while rst_i is high
  assign hs = gnt_found & ~flush_i & ~rst_i;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx] = 1'b1;
  end

  // Issue stage (p0) and tag pipeline (p1); tag stage LATENCY-1 lines up with alu_done_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      iss_vld_p0  <= 1'b0;
      iss_id_p0   <= '0;
      alu_op_o    <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      tag_vld_p1  <= '0;
      tag_kill_p1 <= '0;
      tag_id_p1   <= '0;
    end else begin
      if (hs) begin
        ptr_q     <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
        iss_id_p0 <= gnt_idx;
        alu_op_o  <= req_op_i[gnt_idx*OP_W +: OP_W];
        alu_a_o   <= req_a_i[gnt_idx*DATA_W +: DATA_W];
        alu_b_o   <= req_b_i[gnt_idx*DATA_W +: DATA_W];
      end
      iss_vld_p0     <= hs;
      tag_vld_p1[0]  <= iss_vld_p0;
      tag_kill_p1[0] <= flush_i;
      tag_id_p1[0]   <= iss_id_p0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_p1[i]  <= tag_vld_p1[i-1];
        tag_kill_p1[i] <= tag_kill_p1[i-1] | flush_i;
        tag_id_p1[i]   <= tag_id_p1[i-1];
      end
    end
  end

  assign alu_valid_o = iss_vld_p0;
  assign out_vld     = tag_vld_p1[LATENCY-1];
  assign out_kill    = tag_kill_p1[LATENCY-1] | flush_i;
  assign out_id      = tag_id_p1[LATENCY-1];
  assign busy_o      = iss_vld_p0 | (|tag_vld_p1);

  // Response stage (p2): route result to its owner, flag done/tag disagreement
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (alu_done_i && out_vld && !out_kill) begin
        rsp_valid_o[out_id] <= 1'b1;
        rsp_data_o          <= alu_result_i;
      end
      err_o <= err_o | (alu_done_i & ~out_vld) | (~alu_done_i & out_vld & ~out_kill);
    end
  end

endmodule

// File: tb/tb_primus_alu_arbiter.sv
// Bench for primus_alu_arbiter: behavioural ALU, round-robin grant model and a response scoreboard.
module tb_primus_alu_arbiter;

  localparam int N = 2;
  localparam int DW = 16;
  localparam int OW = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_a, req_b;
  logic            alu_valid, alu_done, flush, busy, err;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_result, rsp_data;
  logic [N-1:0]    rsp_valid;
  logic            spur;

  primus_alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .alu_valid_o(alu_valid), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_done_i(alu_done), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .flush_i(flush), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Behavioural ALU: fixed LAT-cycle pipeline, reset together with the DUT
  logic [LAT-1:0] mv;
  logic [DW-1:0]  mr [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) mv <= '0;
    else begin
      mv    <= {mv[LAT-2:0], alu_valid};
      mr[0] <= alu_fn(alu_op, alu_a, alu_b);
      for (int i = 1; i < LAT; i++) mr[i] <= mr[i-1];
    end
  end
  assign alu_done   = mv[LAT-1] | spur;
  assign alu_result = mr[LAT-1];

  typedef struct { logic [N-1:0] oh; logic [DW-1:0] data; int due; } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mptr = 0;
  logic iss_exp = 1'b0;
  logic [OW-1:0] e_op;
  logic [DW-1:0] e_a, e_b;
  logic exp_err = 1'b0, err_next = 1'b0;
  logic [OW-1:0] s_op [N];
  logic [DW-1:0] s_a [N], s_b [N];
  logic [DW-1:0] last_res;

  function automatic int rr(input logic [N-1:0] vm, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (vm[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    s_op[i] = 4'($urandom_range(0, 4));
    s_a[i]  = 16'($urandom);
    s_b[i]  = 16'($urandom);
  endtask

  // Advance one clock and check the registered outputs against the model
  task automatic tick();
    logic [N-1:0]  eoh;
    logic [DW-1:0] ed;
    @(posedge clk); #1;
    cyc++;
    vectors++;
    if (alu_valid !== iss_exp || (iss_exp && (alu_op !== e_op || alu_a !== e_a || alu_b !== e_b))) begin
      miscompares++;
      $display("FAIL issue cyc=%0d: got v=%b op=%h a=%h b=%h, need v=%b op=%h a=%h b=%h",
               cyc, alu_valid, alu_op, alu_a, alu_b, iss_exp, e_op, e_a, e_b);
    end
    eoh = '0;
    ed  = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      eoh = sbq[0].oh;
      ed  = sbq[0].data;
      void'(sbq.pop_front());
    end
    vectors++;
    if (rsp_valid !== eoh || (eoh != '0 && rsp_data !== ed)) begin
      miscompares++;
      $display("FAIL response cyc=%0d: got v=%b d=%h, need v=%b d=%h", cyc, rsp_valid, rsp_data, eoh, ed);
    end
    exp_err  = exp_err | err_next;
    err_next = 1'b0;
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL err cyc=%0d: got %b, need %b", cyc, err, exp_err);
    end
  endtask

  // Drive requests for the current cycle and check the grant; push expected responses
  task automatic drive(input logic [N-1:0] vm, input logic fl);
    logic [N-1:0] er;
    int g;
    req_valid = vm;
    flush     = fl;
    req_op    = {s_op[1], s_op[0]};
    req_a     = {s_a[1], s_a[0]};
    req_b     = {s_b[1], s_b[0]};
    #1;
    er = '0;
    g  = -1;
    if (!fl && vm != '0) begin
      g = rr(vm, mptr);
      er[g] = 1'b1;
    end
    vectors++;
    if (req_ready !== er) begin
      miscompares++;
      $display("FAIL grant cyc=%0d: got %b, need %b", cyc, req_ready, er);
    end
    iss_exp = 1'b0;
    if (g >= 0) begin
      iss_exp  = 1'b1;
      e_op     = s_op[g];
      e_a      = s_a[g];
      e_b      = s_b[g];
      last_res = alu_fn(s_op[g], s_a[g], s_b[g]);
      sbq.push_back('{oh: er, data: last_res, due: cyc + LAT + 2});
      mptr = (g + 1) % N;
      new_req(g);
    end
    if (fl) sbq.delete();
  endtask

  task automatic step(input logic [N-1:0] vm, input logic fl);
    tick();
    drive(vm, fl);
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, alu_valid, rsp_valid, err, busy} !== '0 ||
        {alu_op, alu_a, alu_b, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b av=%b rv=%b err=%b busy=%b op=%h a=%h b=%h d=%h, need all 0",
               req_ready, alu_valid, rsp_valid, err, busy, alu_op, alu_a, alu_b, rsp_data);
    end
    rst = 1'b0;
    drive('0, 1'b0);
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 1'b0);
      vectors++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL alternate k=%0d: got %b, need %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    repeat (7) step('0, 1'b0);
  endtask

  task automatic test_single();
    s_op[0] = 4'd0;
    s_a[0]  = 16'h0003;
    s_b[0]  = 16'h0004;
    step(2'b01, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        vectors++;
        if (alu_valid !== 1'b1 || alu_a !== 16'h0003 || alu_b !== 16'h0004) begin
          miscompares++;
          $display("FAIL single_issue: got v=%b a=%h b=%h, need v=1 a=0003 b=0004", alu_valid, alu_a, alu_b);
        end
      end
      if (k == 2) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL single_busy: got %b, need 1", busy);
        end
      end
      if (k == 5) begin
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'h0007 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL single_rsp: got v=%b d=%h busy=%b, need v=01 d=0007 busy=0", rsp_valid, rsp_data, busy);
        end
      end
      drive('0, 1'b0);
    end
    repeat (2) step('0, 1'b0);
  endtask

  task automatic test_starvation();
    int first_r1;
    first_r1 = -1;
    step(2'b10, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 1'b0);
      if (req_ready[1] && first_r1 < 0) first_r1 = k;
    end
    vectors++;
    if (first_r1 < 0 || first_r1 > 1) begin
      miscompares++;
      $display("FAIL starvation: requester 1 first granted at cycle %0d, need 0 or 1", first_r1);
    end
    repeat (7) step('0, 1'b0);
  endtask

  task automatic test_flush();
    logic [DW-1:0] want;
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    step(2'b01, 1'b0);
    step('0, 1'b1);
    step(2'b01, 1'b0);
    want = last_res;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== want) begin
          miscompares++;
          $display("FAIL flush_new_rsp: got v=%b d=%h, need v=01 d=%h", rsp_valid, rsp_data, want);
        end
      end
      drive('0, 1'b0);
    end
    repeat (3) step('0, 1'b0);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clean: got err=%b busy=%b, need err=0 busy=0", err, busy);
    end
  endtask

  task automatic test_flush_at_done();
    step(2'b10, 1'b0);
    repeat (3) step('0, 1'b0);
    step('0, 1'b1);
    tick();
    vectors++;
    if (rsp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_at_done: got rsp_valid=%b, need 00", rsp_valid);
    end
    drive('0, 1'b0);
    repeat (4) step('0, 1'b0);
  endtask

  task automatic test_spurious();
    tick();
    spur     = 1'b1;
    err_next = 1'b1;
    drive('0, 1'b0);
    tick();
    spur = 1'b0;
    drive('0, 1'b0);
    repeat (3) step('0, 1'b0);
    vectors++;
    if (err !== 1'b1 || rsp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL spurious_sticky: got err=%b rsp_valid=%b, need err=1 rsp_valid=00", err, rsp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    tick();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, alu_valid, rsp_valid, err, busy} !== '0 ||
        {alu_op, alu_a, alu_b, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_midflight: got rdy=%b av=%b rv=%b err=%b busy=%b op=%h a=%h b=%h d=%h, need all 0",
               req_ready, alu_valid, rsp_valid, err, busy, alu_op, alu_a, alu_b, rsp_data);
    end
    sbq.delete();
    iss_exp = 1'b0;
    exp_err = 1'b0;
    mptr    = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b11, 1'b0);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_ptr: got %b, need 01", req_ready);
    end
    repeat (7) step('0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    spur = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) new_req(i);
    test_reset();
    test_alternate();
    test_single();
    test_starvation();
    test_flush();
    test_flush_at_done();
    test_spurious();
    test_reset_midflight();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses still outstanding, need 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/primus_alu_arbiter.md
# primus_alu_arbiter

Shares one pipelined primus ALU between `N_REQ` requesters, e.g. integer issue ports or a multiply/divide helper. It arbitrates valid/ready requests round-robin and registers the winning operation into the ALU. It tracks each in-flight operation's owner in a tag pipeline matched to the ALU latency, and routes each result back to its requester. It also handles pipeline flush and flags protocol errors from the ALU side.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `DATA_W`, 16, operand/result width
- `OP_W`, 4, ALU opcode width
- `LATENCY`, 3, ALU cycles from `alu_valid_o` to `alu_done_i` (≥1)
- `clk_i`  in  1  clock, all logic on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `req_valid_i`  in  N_REQ  per-requester request valid
- `req_ready_o`  out  N_REQ  per-requester grant (handshake when valid&ready)
- `req_op_i`  in  N_REQ*OP_W  opcodes, requester i at slice i
- `req_a_i`, `req_b_i`  in  N_REQ*DATA_W  operands, requester i at slice i
- `alu_valid_o`  out  1  operation issued to ALU this cycle
- `alu_op_o`  out  OP_W  registered opcode
- `alu_a_o`, `alu_b_o`  out  DATA_W  registered operands
- `alu_done_i`  in  1  ALU result valid
- `alu_result_i`  in  DATA_W  ALU result
- `rsp_valid_o`  out  N_REQ  one-hot result strobe to the owning requester
- `rsp_data_o`  out  DATA_W  result data, shared by all requesters
- `flush_i`  in  1  kill all in-flight and pending operations
- `busy_o`  out  1  any operation in the issue register or tag pipeline
- `err_o`  out  1  sticky protocol error

## Operation
- Arbitration is round-robin over `req_valid_i`, evaluated combinationally each cycle.
  - Priority starts at the requester after the last granted one.
  - After reset, requester 0 has highest priority.
- At most one `req_ready_o` bit is high per cycle, and only for a requester with valid high.
  - `req_ready_o` is all-zero while `flush_i` is high.
  - `req_ready_o` does not depend on requester valid bits other than the arbitration result.
- The arbitration pointer advances only on a completed handshake.
- Requesters hold op and operands stable while valid is high and ready is low. A requester may not drop valid before its handshake.
- Issue stage: a handshake loads op/a/b into the output register. It also pushes tag {valid=1, kill=0, id=i} into tag pipeline stage 0.
- The ALU is fully pipelined with no backpressure, so one issue per cycle is sustained.
- Tag pipeline: `LATENCY` stages, shifting every cycle, aligned so stage `LATENCY-1` coincides with `alu_done_i`.
- Result routing, when `alu_done_i` is high:
  - Output tag valid & !kill: `rsp_valid_o[id]` = 1 and `rsp_data_o` = `alu_result_i`, registered.
  - Output tag valid & kill: result dropped silently.
  - Output tag invalid: `err_o` set.
- `alu_done_i` low while the output tag is valid & !kill also sets `err_o`. `rsp_valid_o` stays 0 for that operation.
- Flush, in the cycle `flush_i` is high:
  - No grant is made.
  - The issue register's contents are killed; `alu_valid_o` is forced 0 next cycle if not yet issued.
  - Every valid tag, including one already presented to the ALU, gets kill=1.
  - Killed results are never delivered. New requests are accepted from the next cycle.
- `err_o` clears only on reset.
- `busy_o` = issue register valid OR any tag valid. It is combinational from registered state.

## Timing
- Reset values:
  - `req_ready_o`, `alu_valid_o`, `rsp_valid_o`, `err_o`, `busy_o` = 0.
  - `alu_op_o`, `alu_a_o`, `alu_b_o`, `rsp_data_o` = 0.
  - All tags invalid; pointer at requester 0.
- Handshake in cycle T gives `alu_valid_o` in T+1, `alu_done_i` expected in T+1+LATENCY, and `rsp_valid_o` in T+2+LATENCY. Default: 5 cycles handshake to response.
- `rsp_valid_o` is a single-cycle pulse per operation. Requesters must accept it; there is no response backpressure.
- Results return in issue order.
- Flush in the same cycle as a result arriving at the tag output: kill applies, and the result is dropped.
- Reset asserted mid-operation clears all in-flight state immediately and asynchronously. Later `alu_done_i` pulses from the pre-reset pipeline set `err_o`, so the ALU must be reset together with this block.

## Test plan
- Requester 0 only, op=ADD, a=0x0003, b=0x0004, T=0 → `alu_valid_o` at T1 with a=3,b=4; `rsp_valid_o`=01, `rsp_data_o`=0x0007 at T5; `busy_o` low at T5.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; one `alu_valid_o` per cycle; responses return in the same order 4 cycles after issue.
- Requester 1 holds valid while requester 0 requests every cycle → requester 1 granted no later than the 2nd cycle; no starvation.
- 3 back-to-back issues, `flush_i` pulsed 2 cycles after the first issue → no `rsp_valid_o` for any of the 3; a new request right after the flush gets a correct response 5 cycles later; `err_o`=0.
- Spurious `alu_done_i` with an empty tag pipeline → `err_o`=1 next cycle and held until `rst_i`; no `rsp_valid_o`.
- `rst_i` asserted while 2 operations are in flight → all outputs 0 immediately; after deassert the pointer is at requester 0, and simultaneous requests grant requester 0 first.
